// File: rtl/tcdm_bank_req_buffer.sv
// Request buffer between the TCDM interconnect and one SRAM bank: a small FIFO absorbs
// bank grant stalls, and a one-stage response pipe aligns r_valid with the bank's read data.
module tcdm_bank_req_buffer #(
    parameter int BANK_SIZE  = 256,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    localparam int ADDR_W    = $clog2(BANK_SIZE),
    localparam int BE_W      = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [ADDR_W-1:0]     add_i,
    input  logic                  wen_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BE_W-1:0]       be_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o,
    output logic                  bank_req_o,
    output logic [ADDR_W-1:0]     bank_add_o,
    output logic                  bank_wen_o,
    output logic [DATA_WIDTH-1:0] bank_wdata_o,
    output logic [BE_W-1:0]       bank_be_o,
    input  logic                  bank_gnt_i,
    input  logic [DATA_WIDTH-1:0] bank_rdata_i,
    output logic                  busy_o
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 1 + DATA_WIDTH + BE_W;

    logic [ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_resp_v;
    logic                  r_resp_rd;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_not_empty;
    logic [ENTRY_W-1:0]    w_head;
    logic [ADDR_W-1:0]     w_head_add;
    logic                  w_head_wen;
    logic [DATA_WIDTH-1:0] w_head_wdata;
    logic [BE_W-1:0]       w_head_be;

    // Full blocks the grant even when the head pops this cycle: no pass-through path.
    assign gnt_o       = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_not_empty = (r_count != '0);
    assign w_push      = req_i & gnt_o;
    assign w_pop       = w_not_empty & bank_gnt_i;

    assign w_head = r_mem[r_rd_ptr];
    assign {w_head_add, w_head_wen, w_head_wdata, w_head_be} = w_head;

    // Storage is not reset, so the bank fields are gated to zero while the FIFO is empty.
    assign bank_req_o   = w_not_empty;
    assign bank_add_o   = w_not_empty ? w_head_add   : '0;
    assign bank_wen_o   = w_not_empty ? w_head_wen   : 1'b0;
    assign bank_wdata_o = w_not_empty ? w_head_wdata : '0;
    assign bank_be_o    = w_not_empty ? w_head_be    : '0;

    assign r_valid_o = r_resp_v;
    assign r_rdata_o = r_resp_rd ? bank_rdata_i : '0;
    assign busy_o    = w_not_empty | r_resp_v;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {add_i, wen_i, wdata_i, be_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_resp_v  <= 1'b0;
            r_resp_rd <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            r_resp_v  <= w_pop;
            r_resp_rd <= w_pop & w_head_wen;
        end
    end

endmodule

// File: tb/tb_tcdm_bank_req_buffer.sv
// Directed bench for tcdm_bank_req_buffer: reset, single write/read latency, bank stall,
// full-with-pop grant, 16-read streaming and reset with traffic in flight.
module tb_tcdm_bank_req_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [7:0]  add_i;
    logic        wen_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        gnt_o;
    logic        r_valid_o;
    logic [31:0] r_rdata_o;
    logic        bank_req_o;
    logic [7:0]  bank_add_o;
    logic        bank_wen_o;
    logic [31:0] bank_wdata_o;
    logic [3:0]  bank_be_o;
    logic        bank_gnt_i;
    logic [31:0] bank_rdata_i;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    logic [7:0]  last_wr_add;
    logic [31:0] last_wr_data;

    always #5 clk_i = ~clk_i;

    tcdm_bank_req_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_rdata_o(r_rdata_o), .bank_req_o(bank_req_o), .bank_add_o(bank_add_o),
        .bank_wen_o(bank_wen_o), .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o),
        .bank_gnt_i(bank_gnt_i), .bank_rdata_i(bank_rdata_i), .busy_o(busy_o)
    );

    // Bank model: remembers the last written word, otherwise returns A5_0000_<addr>.
    always @(posedge clk_i) begin
        if (bank_req_o && bank_gnt_i) begin
            if (bank_wen_o) begin
                bank_rdata_i <= (bank_add_o == last_wr_add) ? last_wr_data : {8'hA5, 16'h0000, bank_add_o};
            end else begin
                last_wr_add  <= bank_add_o;
                last_wr_data <= bank_wdata_o;
            end
        end
    end

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; req_i = 1'b0; add_i = '0; wen_i = 1'b1; wdata_i = '0; be_i = '0; bank_gnt_i = 1'b1;
        step; step;
        n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL reset_gnt: got %b want 1", gnt_o); end
        n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", r_valid_o); end
        n_cmp++; if (bank_req_o !== 1'b0) begin n_err++; $display("FAIL reset_bank_req: got %b want 0", bank_req_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (r_rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", r_rdata_o); end
        n_cmp++; if (bank_add_o !== 8'h0) begin n_err++; $display("FAIL reset_bank_add: got %h want 0", bank_add_o); end
        n_cmp++; if (bank_wdata_o !== 32'h0) begin n_err++; $display("FAIL reset_bank_wdata: got %h want 0", bank_wdata_o); end
        rst_i = 1'b0;
        step;
    endtask

    task automatic test_single_write;
        req_i = 1'b1; add_i = 8'h05; wen_i = 1'b0; wdata_i = 32'hDEADBEEF; be_i = 4'hF; bank_gnt_i = 1'b1;
        #1;
        n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL wr_gnt: got %b want 1", gnt_o); end
        n_cmp++; if (bank_req_o !== 1'b0) begin n_err++; $display("FAIL wr_no_bypass: got %b want 0", bank_req_o); end
        step;
        req_i = 1'b0; #1;
        n_cmp++; if (bank_req_o !== 1'b1) begin n_err++; $display("FAIL wr_bank_req: got %b want 1", bank_req_o); end
        n_cmp++; if (bank_add_o !== 8'h05) begin n_err++; $display("FAIL wr_bank_add: got %h want 05", bank_add_o); end
        n_cmp++; if (bank_wen_o !== 1'b0) begin n_err++; $display("FAIL wr_bank_wen: got %b want 0", bank_wen_o); end
        n_cmp++; if (bank_wdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_bank_wdata: got %h want deadbeef", bank_wdata_o); end
        n_cmp++; if (bank_be_o !== 4'hF) begin n_err++; $display("FAIL wr_bank_be: got %h want f", bank_be_o); end
        n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL wr_rvalid_early: got %b want 0", r_valid_o); end
        step; #1;
        n_cmp++; if (r_valid_o !== 1'b1) begin n_err++; $display("FAIL wr_rvalid: got %b want 1", r_valid_o); end
        n_cmp++; if (r_rdata_o !== 32'h0) begin n_err++; $display("FAIL wr_rdata: got %h want 0", r_rdata_o); end
        step; #1;
        n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL wr_rvalid_once: got %b want 0", r_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL wr_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_single_read;
        step;
        req_i = 1'b1; add_i = 8'h05; wen_i = 1'b1; wdata_i = 32'h0; be_i = 4'hF; bank_gnt_i = 1'b1;
        #1;
        n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL rd_gnt: got %b want 1", gnt_o); end
        step;
        req_i = 1'b0; #1;
        n_cmp++; if (bank_req_o !== 1'b1 || bank_wen_o !== 1'b1) begin n_err++; $display("FAIL rd_bank_req: got req %b wen %b want 1 1", bank_req_o, bank_wen_o); end
        n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_early: got %b want 0", r_valid_o); end
        step; #1;
        n_cmp++; if (r_valid_o !== 1'b1) begin n_err++; $display("FAIL rd_rvalid: got %b want 1", r_valid_o); end
        n_cmp++; if (r_rdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata: got %h want deadbeef", r_rdata_o); end
        step; #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rd_busy_end: got %b want 0", busy_o); end
        n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_once: got %b want 0", r_valid_o); end
    endtask

    task automatic test_stall_and_full;
        step;
        req_i = 1'b1; add_i = 8'h10; wen_i = 1'b1; bank_gnt_i = 1'b0; #1;
        n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL stall_gnt_c1: got %b want 1", gnt_o); end
        step;
        add_i = 8'h11; #1;
        n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL stall_gnt_c2: got %b want 1", gnt_o); end
        n_cmp++; if (bank_add_o !== 8'h10) begin n_err++; $display("FAIL stall_head_c2: got %h want 10", bank_add_o); end
        step;
        add_i = 8'h12;
        for (int c = 3; c <= 4; c++) begin
            #1;
            n_cmp++; if (gnt_o !== 1'b0) begin n_err++; $display("FAIL stall_gnt_full_c%0d: got %b want 0", c, gnt_o); end
            n_cmp++; if (bank_req_o !== 1'b1 || bank_add_o !== 8'h10) begin n_err++; $display("FAIL stall_head_c%0d: got req %b add %h want 1 10", c, bank_req_o, bank_add_o); end
            step;
        end
        bank_gnt_i = 1'b1; #1;
        n_cmp++; if (gnt_o !== 1'b0) begin n_err++; $display("FAIL full_pop_gnt: got %b want 0", gnt_o); end
        n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL full_pop_rvalid: got %b want 0", r_valid_o); end
        step; #1;
        n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL full_next_gnt: got %b want 1", gnt_o); end
        n_cmp++; if (r_valid_o !== 1'b1 || r_rdata_o !== 32'hA5000010) begin n_err++; $display("FAIL stall_resp0: got v %b d %h want 1 a5000010", r_valid_o, r_rdata_o); end
        step;
        req_i = 1'b0; #1;
        n_cmp++; if (r_valid_o !== 1'b1 || r_rdata_o !== 32'hA5000011) begin n_err++; $display("FAIL stall_resp1: got v %b d %h want 1 a5000011", r_valid_o, r_rdata_o); end
        step; #1;
        n_cmp++; if (r_valid_o !== 1'b1 || r_rdata_o !== 32'hA5000012) begin n_err++; $display("FAIL stall_resp2: got v %b d %h want 1 a5000012", r_valid_o, r_rdata_o); end
        step; #1;
        n_cmp++; if (r_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL stall_end: got v %b busy %b want 0 0", r_valid_o, busy_o); end
    endtask

    task automatic test_back_to_back;
        int sent, n_valid, first_c, last_c;
        logic [7:0] a;
        sent = 0; n_valid = 0; first_c = -1; last_c = -1;
        exp_q.delete();
        step;
        bank_gnt_i = 1'b1; wen_i = 1'b1;
        for (int c = 0; c < 24; c++) begin
            a = 8'h20 + 8'(sent);
            req_i = (sent < 16); add_i = a;
            #1;
            if (r_valid_o) begin
                n_valid++;
                if (first_c < 0) first_c = c;
                last_c = c;
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL stream_extra: got %h want no response", r_rdata_o); end
                else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (r_rdata_o !== e) begin n_err++; $display("FAIL stream_data: got %h want %h", r_rdata_o, e); end
                end
            end
            if (req_i) begin
                n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL stream_gnt_c%0d: got %b want 1", c, gnt_o); end
                if (gnt_o) begin exp_q.push_back({8'hA5, 16'h0000, a}); sent++; end
            end
            step;
        end
        req_i = 1'b0;
        n_cmp++; if (n_valid !== 16) begin n_err++; $display("FAIL stream_count: got %0d want 16", n_valid); end
        n_cmp++; if (first_c !== 2 || last_c !== 17) begin n_err++; $display("FAIL stream_window: got %0d..%0d want 2..17", first_c, last_c); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL stream_lost: got %0d outstanding want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        wen_i = 1'b1; bank_gnt_i = 1'b0;
        req_i = 1'b1; add_i = 8'h30; step;
        add_i = 8'h31; step;
        bank_gnt_i = 1'b1; add_i = 8'h32; step;
        bank_gnt_i = 1'b0; #1;
        n_cmp++; if (r_valid_o !== 1'b1 || bank_req_o !== 1'b1) begin n_err++; $display("FAIL mid_setup: got v %b req %b want 1 1", r_valid_o, bank_req_o); end
        rst_i = 1'b1; #1;
        n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_rvalid: got %b want 0", r_valid_o); end
        n_cmp++; if (bank_req_o !== 1'b0 || bank_add_o !== 8'h0) begin n_err++; $display("FAIL mid_rst_bank: got req %b add %h want 0 00", bank_req_o, bank_add_o); end
        n_cmp++; if (busy_o !== 1'b0 || gnt_o !== 1'b1) begin n_err++; $display("FAIL mid_rst_busy_gnt: got busy %b gnt %b want 0 1", busy_o, gnt_o); end
        n_cmp++; if (r_rdata_o !== 32'h0) begin n_err++; $display("FAIL mid_rst_rdata: got %h want 0", r_rdata_o); end
        req_i = 1'b0;
        step; step;
        rst_i = 1'b0; bank_gnt_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (r_valid_o !== 1'b0 || bank_req_o !== 1'b0) begin n_err++; $display("FAIL mid_post_c%0d: got v %b req %b want 0 0", c, r_valid_o, bank_req_o); end
            step;
        end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_single_read;
        test_stall_and_full;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
